// File: rtl/random_coord_gen.sv
// Random food-coordinate generator: free-running 16-bit LFSR, rejection-sampled
// (x,y) inside [MIN,MAX], re-drawn until the board occupancy logic reports a free cell.
module random_coord_gen #(
  parameter int          X_W       = 8,
  parameter int          Y_W       = 7,
  parameter int          X_MIN     = 3,
  parameter int          X_MAX     = 157,
  parameter int          Y_MIN     = 3,
  parameter int          Y_MAX     = 117,
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter int          MAX_TRIES = 64
) (
  input  logic           clock,
  input  logic           resetn,
  input  logic           seed_load,
  input  logic [15:0]    seed_in,
  input  logic           req_valid,
  output logic           req_ready,
  output logic           occ_req,
  output logic [X_W-1:0] occ_x,
  output logic [Y_W-1:0] occ_y,
  input  logic           occ_valid,
  input  logic           occ_hit,
  output logic           coord_valid,
  input  logic           coord_ready,
  output logic [X_W-1:0] coord_x,
  output logic [Y_W-1:0] coord_y,
  output logic           coord_fail,
  output logic [15:0]    lfsr_state
);
  localparam int TW = $clog2(MAX_TRIES + 1);
  localparam logic [X_W-1:0] XLO = X_W'(X_MIN);
  localparam logic [X_W-1:0] XHI = X_W'(X_MAX);
  localparam logic [Y_W-1:0] YLO = Y_W'(Y_MIN);
  localparam logic [Y_W-1:0] YHI = Y_W'(Y_MAX);

  typedef enum logic [2:0] {IDLE, GEN_X, GEN_Y, QUERY, WAIT_OCC, DONE} state_t;

  state_t         state_q, state_d;
  logic [15:0]    lfsr_q, lfsr_d;
  logic [TW-1:0]  tries_q, tries_d, tries_inc;
  logic [X_W-1:0] cand_x_q, cand_x_d, res_x_q, res_x_d;
  logic [Y_W-1:0] cand_y_q, cand_y_d, res_y_q, res_y_d;
  logic           fail_q, fail_d;
  logic [X_W-1:0] cx;
  logic [Y_W-1:0] cy;
  logic           x_ok, y_ok, give_up;

  // y comes from the top bits so it is not a shifted copy of the x bits
  assign cx        = lfsr_q[X_W-1:0];
  assign cy        = lfsr_q[15 -: Y_W];
  assign x_ok      = (cx >= XLO) && (cx <= XHI);
  assign y_ok      = (cy >= YLO) && (cy <= YHI);
  assign tries_inc = tries_q + TW'(1);
  assign give_up   = (tries_inc == TW'(MAX_TRIES));

  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    if (seed_load)            lfsr_d = (seed_in == 16'h0) ? SEED : seed_in;
    else if (lfsr_q == 16'h0) lfsr_d = SEED;
  end

  always_comb begin
    state_d  = state_q;
    tries_d  = tries_q;
    cand_x_d = cand_x_q;
    cand_y_d = cand_y_q;
    res_x_d  = res_x_q;
    res_y_d  = res_y_q;
    fail_d   = fail_q;
    unique case (state_q)
      IDLE: if (req_valid) begin
        state_d = GEN_X;
        tries_d = '0;
        fail_d  = 1'b0;
      end
      GEN_X: if (x_ok) begin
        cand_x_d = cx;
        state_d  = GEN_Y;
      end else begin
        tries_d = tries_inc;
        if (give_up) begin state_d = DONE; fail_d = 1'b1; end
      end
      GEN_Y: if (y_ok) begin
        cand_y_d = cy;
        state_d  = QUERY;
      end else begin
        tries_d = tries_inc;
        if (give_up) begin state_d = DONE; fail_d = 1'b1; end
      end
      QUERY: state_d = WAIT_OCC;
      WAIT_OCC: if (occ_valid) begin
        if (!occ_hit) begin
          res_x_d = cand_x_q;
          res_y_d = cand_y_q;
          fail_d  = 1'b0;
          state_d = DONE;
        end else begin
          tries_d = tries_inc;
          if (give_up) begin state_d = DONE; fail_d = 1'b1; end
          else                 state_d = GEN_X;
        end
      end
      DONE: if (coord_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q  <= IDLE;
      lfsr_q   <= SEED;
      tries_q  <= '0;
      cand_x_q <= XLO;
      cand_y_q <= YLO;
      res_x_q  <= XLO;
      res_y_q  <= YLO;
      fail_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      tries_q  <= tries_d;
      cand_x_q <= cand_x_d;
      cand_y_q <= cand_y_d;
      res_x_q  <= res_x_d;
      res_y_q  <= res_y_d;
      fail_q   <= fail_d;
    end
  end

  assign req_ready   = (state_q == IDLE);
  assign occ_req     = (state_q == QUERY);
  assign coord_valid = (state_q == DONE);
  assign occ_x       = cand_x_q;
  assign occ_y       = cand_y_q;
  assign coord_x     = res_x_q;
  assign coord_y     = res_y_q;
  assign coord_fail  = fail_q;
  assign lfsr_state  = lfsr_q;
endmodule
